// File: rtl/main_memory_responder_if.sv
// main_memory_responder_if
//   Request/response bundle between a cache controller (master) and the
//   main-memory responder (slave).
//   master -> slave : load, store, loadIndex, dataIn
//   slave -> master : dataFromMain, doneLoading, busy
interface main_memory_responder_if #(
    parameter int ADDR_W = 4
);
    logic              load;
    logic              store;
    logic [ADDR_W-1:0] loadIndex;
    logic [63:0]       dataIn;
    logic [63:0]       dataFromMain;
    logic              doneLoading;
    logic              busy;

    modport master (
        output load, store, loadIndex, dataIn,
        input  dataFromMain, doneLoading, busy
    );

    modport slave (
        input  load, store, loadIndex, dataIn,
        output dataFromMain, doneLoading, busy
    );
endinterface

// File: rtl/main_memory_responder.sv
// main_memory_responder
//   Main-memory model answering two-word line fills and writebacks from a
//   cache controller after a fixed access latency.
//   Ports:
//     clk   - rising-edge clock
//     reset - asynchronous active-low reset; restores the memory pattern
//     bus   - main_memory_responder_if.slave
//             load/store      : request strobes, sampled only when idle
//             loadIndex       : word address; line base = index mod DEPTH, bit0 cleared
//             dataIn          : writeback line {odd word, even word}
//             dataFromMain    : last loaded line, held until the next load
//             doneLoading     : one-cycle completion pulse (load and store)
//             busy            : request in flight (BUSY and DONE states)
module main_memory_responder #(
    parameter int DEPTH   = 8,
    parameter int ADDR_W  = 4,
    parameter int LATENCY = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    main_memory_responder_if.slave       bus
);
    // A latency of 0 behaves like 1.
    localparam int LAT_EFF = (LATENCY < 1) ? 1 : LATENCY;
    localparam int IDX_W   = $clog2(DEPTH);
    localparam int CNT_W   = (LAT_EFF > 1) ? $clog2(LAT_EFF) : 1;

    localparam logic [CNT_W-1:0] CNT_INIT  = CNT_W'(LAT_EFF - 1);
    localparam logic [31:0]      EVEN_INIT = 32'hAAAAFFFF;
    localparam logic [31:0]      ODD_INIT  = 32'hFFFFAAAA;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_load_q, is_load_d;
    logic [IDX_W-1:0]   base_q, base_d;
    logic [63:0]        wdata_q, wdata_d;
    logic [63:0]        rdata_q, rdata_d;
    logic [31:0]        mem_q [DEPTH];
    logic [31:0]        mem_d [DEPTH];

    logic [IDX_W-1:0]   req_base;
    logic [IDX_W-1:0]   odd_addr;
    logic               unused_index_bits;

    // Index bits above log2(DEPTH) wrap away; bit0 is dropped to align the line.
    assign req_base          = bus.loadIndex[IDX_W-1:0] & ~IDX_W'(1);
    assign odd_addr          = base_q | IDX_W'(1);
    assign unused_index_bits = ^bus.loadIndex;

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through the
        // case leaves one unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_load_d = is_load_q;
        base_d    = base_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        mem_d     = mem_q;

        case (state_q)
            S_IDLE: begin
                // Load has priority when both strobes are high; the store is dropped.
                if (bus.load || bus.store) begin
                    is_load_d = bus.load;
                    base_d    = req_base;
                    wdata_d   = bus.dataIn;
                    cnt_d     = CNT_INIT;
                    state_d   = S_BUSY;
                end
            end
            S_BUSY: begin
                // The access takes effect on the edge that enters DONE.
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    if (is_load_q) begin
                        rdata_d = {mem_q[odd_addr], mem_q[base_q]};
                    end else begin
                        mem_d[base_q]   = wdata_q[31:0];
                        mem_d[odd_addr] = wdata_q[63:32];
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            is_load_q <= 1'b0;
            base_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            // NOTE: the storage array is reset on purpose: reset must restore the
            // known fill pattern, so it is built from flops rather than a RAM macro.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= (i % 2 == 1) ? ODD_INIT : EVEN_INIT;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_load_q <= is_load_d;
            base_q    <= base_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            mem_q     <= mem_d;
        end
    end

    assign bus.dataFromMain = rdata_q;
    assign bus.doneLoading  = (state_q == S_DONE);
    assign bus.busy         = (state_q != S_IDLE);
endmodule

// File: tb/tb_main_memory_responder.sv
// tb_main_memory_responder
//   Self-checking bench for main_memory_responder. A transaction-level model
//   (cycle stamps, word array) predicts busy/doneLoading/dataFromMain and is
//   compared with the DUT on every falling edge; directed cases pin the model
//   with literal values, then randomized requests exercise the rest.
module tb_main_memory_responder;
    localparam int DEPTH   = 8;
    localparam int ADDR_W  = 4;
    localparam int LATENCY = 4;

    localparam logic [31:0] EVEN_INIT = 32'hAAAAFFFF;
    localparam logic [31:0] ODD_INIT  = 32'hFFFFAAAA;
    localparam logic [63:0] LINE_INIT = 64'hFFFFAAAA_AAAAFFFF;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    main_memory_responder_if #(.ADDR_W(ADDR_W)) bus_if ();

    main_memory_responder #(
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .LATENCY (LATENCY)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus_if)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- reference model ----------------
    logic [31:0] m_mem [DEPTH];
    logic [63:0] m_data;
    logic [63:0] m_wdata;
    bit          m_active;
    bit          m_is_load;
    int          m_base;
    int          m_acc;
    int          m_due;
    int          m_ready;
    int          cyc = 0;

    function automatic bit m_done();
        return m_active && (cyc == m_due);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = (i % 2 == 1) ? ODD_INIT : EVEN_INIT;
        m_data   = '0;
        m_active = 0;
        m_ready  = 0;
    endtask

    // One rising edge: a request is in flight from its acceptance edge through
    // the edge LATENCY later (where it takes effect); the following edge is
    // spent returning to idle, and only after that can a new request be taken.
    task automatic model_edge();
        int lat;
        if (!rst_n) return;
        lat = (LATENCY < 1) ? 1 : LATENCY;
        cyc++;
        if (m_active && cyc == m_due) begin
            if (m_is_load) begin
                m_data = {m_mem[m_base + 1], m_mem[m_base]};
            end else begin
                m_mem[m_base]     = m_wdata[31:0];
                m_mem[m_base + 1] = m_wdata[63:32];
            end
        end else if (m_active && cyc == m_due + 1) begin
            m_active = 0;
            m_ready  = cyc + 1;
        end
        if (!m_active && cyc >= m_ready && (bus_if.load || bus_if.store)) begin
            m_active  = 1;
            m_is_load = bus_if.load;
            m_base    = (int'(bus_if.loadIndex) % DEPTH) & ~1;
            m_wdata   = bus_if.dataIn;
            m_acc     = cyc;
            m_due     = cyc + lat;
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: DUT against model on every falling edge.
    always @(negedge clk) begin
        check("busy",         64'(bus_if.busy),        64'(m_active));
        check("doneLoading",  64'(bus_if.doneLoading), 64'(m_done()));
        check("dataFromMain", bus_if.dataFromMain,     m_data);
    end

    // ---------------- stimulus helpers ----------------
    // Advance one cycle; inputs are changed 2 time units after the falling edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        #2;
    endtask

    task automatic wait_accept(output bit ok);
        ok = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (m_active && m_acc == cyc) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic wait_done(output int n);
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (m_done()) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic do_request(input bit ld, input bit st, input logic [ADDR_W-1:0] idx,
                              input logic [63:0] din, input bit scramble,
                              output logic [63:0] resp);
        bit ok;
        int n;
        bus_if.load      = ld;
        bus_if.store     = st;
        bus_if.loadIndex = idx;
        bus_if.dataIn    = din;
        wait_accept(ok);
        check("accepted", 64'(ok), 64'd1);
        if (scramble) begin
            bus_if.load      = 1'($urandom_range(0, 1));
            bus_if.store     = 1'($urandom_range(0, 1));
            bus_if.loadIndex = ADDR_W'($urandom);
            bus_if.dataIn    = {$urandom, $urandom};
        end
        wait_done(n);
        check("done_seen", 64'(n > 0), 64'd1);
        resp             = bus_if.dataFromMain;
        bus_if.load      = 1'b0;
        bus_if.store     = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [63:0] resp;
        bit          ok;
        int          n;

        bus_if.load      = 1'b0;
        bus_if.store     = 1'b0;
        bus_if.loadIndex = '0;
        bus_if.dataIn    = '0;
        model_reset();
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;

        // Reset state.
        check("reset_data", bus_if.dataFromMain,     64'd0);
        check("reset_busy", 64'(bus_if.busy),        64'd0);
        check("reset_done", 64'(bus_if.doneLoading), 64'd0);

        // Load index 0: busy after acceptance, done exactly LATENCY edges later.
        bus_if.load      = 1'b1;
        bus_if.loadIndex = 4'd0;
        tick();
        check("load0_busy_after_accept", 64'(bus_if.busy),        64'd1);
        check("load0_no_early_done",     64'(bus_if.doneLoading), 64'd0);
        for (int i = 1; i < LATENCY; i++) begin
            tick();
            check("load0_no_early_done", 64'(bus_if.doneLoading), 64'd0);
        end
        tick();
        check("load0_done",  64'(bus_if.doneLoading), 64'd1);
        check("load0_data",  bus_if.dataFromMain,     LINE_INIT);
        bus_if.load = 1'b0;
        tick();
        check("load0_idle_busy", 64'(bus_if.busy),        64'd0);
        check("load0_idle_done", 64'(bus_if.doneLoading), 64'd0);

        // Odd / wrapped index: 4'b1101 -> base 4.
        do_request(1'b1, 1'b0, 4'b1101, 64'd0, 1'b0, resp);
        check("wrap_load", resp, LINE_INIT);

        // Store then read back through the odd index of the same line.
        do_request(1'b0, 1'b1, 4'd2, 64'h12345678_DEADBEEF, 1'b0, resp);
        check("store_keeps_data", resp, LINE_INIT);
        do_request(1'b1, 1'b0, 4'd3, 64'd0, 1'b0, resp);
        check("raw_load", resp, 64'h12345678_DEADBEEF);
        do_request(1'b1, 1'b0, 4'd0, 64'd0, 1'b0, resp);
        check("neighbour_unchanged", resp, LINE_INIT);

        // Load and store together: the load wins, the store never happens.
        do_request(1'b1, 1'b1, 4'd6, 64'd0, 1'b0, resp);
        check("both_load_wins", resp, LINE_INIT);
        do_request(1'b1, 1'b0, 4'd6, 64'd0, 1'b0, resp);
        check("both_store_ignored", resp, LINE_INIT);

        // Inputs changed during BUSY do not affect the latched request.
        do_request(1'b0, 1'b1, 4'd0, 64'hCAFEF00D_01234567, 1'b0, resp);
        bus_if.load      = 1'b1;
        bus_if.loadIndex = 4'd0;
        wait_accept(ok);
        check("toggle_accepted", 64'(ok), 64'd1);
        bus_if.load      = 1'b0;
        bus_if.loadIndex = 4'd6;
        wait_done(n);
        check("toggle_latency", 64'(n), 64'(LATENCY));
        check("toggle_data", bus_if.dataFromMain, 64'hCAFEF00D_01234567);
        tick();

        // Reset during a store in flight: abort, outputs clear, pattern restored.
        bus_if.store     = 1'b1;
        bus_if.loadIndex = 4'd4;
        bus_if.dataIn    = 64'h55556666_77778888;
        wait_accept(ok);
        check("rst_store_accepted", 64'(ok), 64'd1);
        tick();
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_mid_data", bus_if.dataFromMain,     64'd0);
        check("rst_mid_busy", 64'(bus_if.busy),        64'd0);
        check("rst_mid_done", 64'(bus_if.doneLoading), 64'd0);
        bus_if.store = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (LATENCY + 2) tick();
        do_request(1'b1, 1'b0, 4'd4, 64'd0, 1'b0, resp);
        check("rst_no_store", resp, LINE_INIT);
        do_request(1'b1, 1'b0, 4'd2, 64'd0, 1'b0, resp);
        check("rst_pattern_restored", resp, LINE_INIT);

        // Randomized traffic, checked cycle by cycle against the model.
        for (int k = 0; k < 60; k++) begin
            int r;
            r = int'($urandom_range(0, 9));
            do_request(r < 5, r >= 4, ADDR_W'($urandom), {$urandom, $urandom},
                       1'($urandom_range(0, 1)), resp);
            repeat ($urandom_range(0, 2)) tick();
        end
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
